// File: rtl/tv80_busrq_arbiter.sv
// tv80_busrq_arbiter: lends the tv80s memory bus to one external master
// through the Z80 BUSRQ/BUSAK handshake. Bursts are capped at MAX_HOLD
// granted cycles and the CPU keeps the bus for CPU_SLOT cycles after each
// release before the next request is raised.
module tv80_busrq_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CPU_SLOT = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        cpu_busrq_n,
  input  logic        cpu_busak_n,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_do,
  input  logic        cpu_mreq_n,
  input  logic        cpu_wr_n,
  input  logic        dma_req,
  output logic        dma_gnt,
  input  logic [15:0] dma_a,
  input  logic [7:0]  dma_do,
  input  logic        dma_we,
  output logic [15:0] mem_a,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic [15:0] grant_count
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int CW = (CPU_SLOT > 0) ? $clog2(CPU_SLOT + 1) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [CW-1:0] COOL_LOAD = CW'(CPU_SLOT);

  typedef enum logic [1:0] {IDLE, REQ, GRANT, RELEASE} state_t;

  state_t          state_q, state_d;
  logic            busrq_n_q, busrq_n_d;
  logic            dma_gnt_q, dma_gnt_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [CW-1:0]   cool_cnt_q, cool_cnt_d;
  logic [15:0]     grant_count_q, grant_count_d;

  // Next-state logic: handshake sequencing, burst limit and CPU cool-down.
  always_comb begin
    state_d       = state_q;
    busrq_n_d     = busrq_n_q;
    dma_gnt_d     = dma_gnt_q;
    hold_cnt_d    = hold_cnt_q;
    cool_cnt_d    = cool_cnt_q;
    grant_count_d = grant_count_q;
    case (state_q)
      IDLE: begin
        if (cool_cnt_q != '0) cool_cnt_d = cool_cnt_q - CW'(1);
        if (dma_req && (cool_cnt_q == '0)) begin
          state_d   = REQ;
          busrq_n_d = 1'b0;
        end
      end
      REQ: begin
        // A withdrawn request wins over a simultaneous acknowledge.
        if (!dma_req) begin
          state_d   = RELEASE;
          busrq_n_d = 1'b1;
        end else if (!cpu_busak_n) begin
          state_d    = GRANT;
          dma_gnt_d  = 1'b1;
          hold_cnt_d = '0;
        end
      end
      GRANT: begin
        hold_cnt_d = hold_cnt_q + HW'(1);
        // Master done, burst cap reached, or CPU took the bus back early:
        // all collapse into one release and one counted grant.
        if (!dma_req || cpu_busak_n || (hold_cnt_q == HOLD_LAST)) begin
          state_d       = RELEASE;
          dma_gnt_d     = 1'b0;
          busrq_n_d     = 1'b1;
          hold_cnt_d    = '0;
          grant_count_d = grant_count_q + 16'd1;
        end
      end
      RELEASE: begin
        if (cpu_busak_n) begin
          state_d    = IDLE;
          cool_cnt_d = COOL_LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbiter state and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      busrq_n_q     <= 1'b1;
      dma_gnt_q     <= 1'b0;
      hold_cnt_q    <= '0;
      cool_cnt_q    <= '0;
      grant_count_q <= '0;
    end else begin
      state_q       <= state_d;
      busrq_n_q     <= busrq_n_d;
      dma_gnt_q     <= dma_gnt_d;
      hold_cnt_q    <= hold_cnt_d;
      cool_cnt_q    <= cool_cnt_d;
      grant_count_q <= grant_count_d;
    end
  end

  assign cpu_busrq_n = busrq_n_q;
  assign dma_gnt     = dma_gnt_q;
  assign grant_count = grant_count_q;

  // Memory-side mux: the external master's strobe only counts while granted.
  assign mem_a     = dma_gnt_q ? dma_a  : cpu_a;
  assign mem_wdata = dma_gnt_q ? dma_do : cpu_do;
  assign mem_we    = dma_gnt_q ? dma_we : (~cpu_wr_n & ~cpu_mreq_n);

endmodule

// File: tb/tb_tv80_busrq_arbiter.sv
// Randomized bench for tv80_busrq_arbiter with a behavioural CPU
// (random BUSAK latency) and a burst-level expectation model.
module tb_tv80_busrq_arbiter;

  localparam int MAX_HOLD = 16;
  localparam int CPU_SLOT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_busrq_n;
  logic        cpu_busak_n;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_do;
  logic        cpu_mreq_n;
  logic        cpu_wr_n;
  logic        dma_req;
  logic        dma_gnt;
  logic [15:0] dma_a;
  logic [7:0]  dma_do;
  logic        dma_we;
  logic [15:0] mem_a;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [15:0] grant_count;

  tv80_busrq_arbiter #(.MAX_HOLD(MAX_HOLD), .CPU_SLOT(CPU_SLOT)) dut (
    .clk(clk), .reset(reset),
    .cpu_busrq_n(cpu_busrq_n), .cpu_busak_n(cpu_busak_n),
    .cpu_a(cpu_a), .cpu_do(cpu_do), .cpu_mreq_n(cpu_mreq_n), .cpu_wr_n(cpu_wr_n),
    .dma_req(dma_req), .dma_gnt(dma_gnt),
    .dma_a(dma_a), .dma_do(dma_do), .dma_we(dma_we),
    .mem_a(mem_a), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .grant_count(grant_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t_ack = 0;
  int t_rel = 0;
  int ack_wait = 0;
  int rel_wait = 0;
  int exp_cnt  = 0;
  bit cpu_freeze = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return cpu_busrq_n;
      1:       return dma_gnt;
      default: return cpu_busak_n;
    endcase
  endfunction

  // One clock: sample after the edge, run the CPU model, scramble bus traffic,
  // then check the memory mux against its defining rule.
  task automatic tick();
    logic exp_we;
    @(posedge clk);
    #1;
    cyc++;
    if (!cpu_freeze) begin
      if (cpu_busrq_n === 1'b0 && cpu_busak_n === 1'b1) begin
        if (ack_wait == 0) begin
          cpu_busak_n = 1'b0;
          t_ack = cyc;
          rel_wait = $urandom_range(0, 3);
        end else ack_wait--;
      end else if (cpu_busrq_n === 1'b1 && cpu_busak_n === 1'b0) begin
        if (rel_wait == 0) begin
          cpu_busak_n = 1'b1;
          t_rel = cyc;
          ack_wait = $urandom_range(0, 4);
        end else rel_wait--;
      end
    end
    cpu_a      = 16'($urandom);
    cpu_do     = 8'($urandom);
    cpu_mreq_n = 1'($urandom);
    cpu_wr_n   = 1'($urandom);
    dma_a      = 16'($urandom);
    dma_do     = 8'($urandom);
    dma_we     = 1'($urandom);
    #1;
    exp_we = dma_gnt ? dma_we : (!cpu_wr_n && !cpu_mreq_n);
    check("mux_a",  int'(mem_a),     int'(dma_gnt ? dma_a : cpu_a));
    check("mux_wd", int'(mem_wdata), int'(dma_gnt ? dma_do : cpu_do));
    check("mux_we", int'(mem_we),    int'(exp_we));
  endtask

  task automatic wait_for(input string tag, input int sel, input logic val, input int bound);
    int n = 0;
    while (sig(sel) !== val && n < bound) begin
      tick();
      n++;
    end
    check(tag, int'(sig(sel)), int'(val));
  endtask

  task automatic settle();
    wait_for("settle_busak", 2, 1'b1, 50);
    repeat (CPU_SLOT + 3) tick();
  endtask

  // Master wants n granted cycles; expect splits of at most MAX_HOLD with a
  // CPU_SLOT cool-down plus re-handshake between them.
  task automatic run_burst(input int n);
    int remaining = n;
    int seg;
    int t_req;
    int segs = 0;
    dma_req = 1'b1;
    t_req = cyc;
    while (remaining > 0 && segs < 10) begin
      wait_for("busrq_low", 0, 1'b0, 100);
      if (segs == 0) check("req_to_busrq", cyc - t_req, 1);
      else           check("cpu_slot_gap", cyc - t_rel, CPU_SLOT + 2);
      check("gnt_before_ack", int'(dma_gnt), 0);
      wait_for("gnt_high", 1, 1'b1, 100);
      check("ack_to_gnt", cyc - t_ack, 1);
      seg = 0;
      while (dma_gnt === 1'b1 && seg < MAX_HOLD + 2) begin
        seg++;
        if (seg == remaining) dma_req = 1'b0;
        tick();
      end
      check("gnt_fall", int'(dma_gnt), 0);
      check("gnt_len", seg, (remaining < MAX_HOLD) ? remaining : MAX_HOLD);
      exp_cnt++;
      check("grant_count", int'(grant_count), exp_cnt & 16'hffff);
      check("busrq_release", int'(cpu_busrq_n), 1);
      remaining -= seg;
      segs++;
    end
    dma_req = 1'b0;
    settle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    dma_req = 1'b1;
    cpu_busak_n = 1'b1;
    cpu_a = '0; cpu_do = '0; cpu_mreq_n = 1'b1; cpu_wr_n = 1'b1;
    dma_a = '0; dma_do = '0; dma_we = 1'b0;

    // Reset dominates a pending request.
    repeat (3) begin
      tick();
      check("rst_busrq", int'(cpu_busrq_n), 1);
      check("rst_gnt",   int'(dma_gnt), 0);
      check("rst_count", int'(grant_count), 0);
    end
    reset = 1'b0;
    tick();
    check("post_rst_busrq", int'(cpu_busrq_n), 0);
    dma_req = 1'b0;
    tick();
    check("abort_busrq", int'(cpu_busrq_n), 1);
    check("abort_gnt",   int'(dma_gnt), 0);
    settle();

    // Directed bursts: short, exactly the cap, single cycle, and split.
    run_burst(3);
    run_burst(MAX_HOLD);
    run_burst(1);
    run_burst(40);

    // Request withdrawn before the CPU acknowledges.
    cpu_freeze = 1'b1;
    dma_req = 1'b1;
    wait_for("wd_busrq_low", 0, 1'b0, 20);
    dma_req = 1'b0;
    tick();
    check("wd_busrq", int'(cpu_busrq_n), 1);
    repeat (3) begin
      tick();
      check("wd_gnt",   int'(dma_gnt), 0);
      check("wd_count", int'(grant_count), exp_cnt);
    end
    cpu_freeze = 1'b0;
    settle();

    // CPU drops BUSAK in the middle of a grant.
    dma_req = 1'b1;
    wait_for("viol_gnt_high", 1, 1'b1, 100);
    repeat (2) tick();
    cpu_freeze = 1'b1;
    cpu_busak_n = 1'b1;
    tick();
    check("viol_gnt", int'(dma_gnt), 0);
    check("viol_busrq", int'(cpu_busrq_n), 1);
    exp_cnt++;
    check("viol_count", int'(grant_count), exp_cnt);
    dma_req = 1'b0;
    cpu_freeze = 1'b0;
    settle();

    // Random burst lengths.
    for (int i = 0; i < 6; i++) run_burst($urandom_range(1, 40));

    // Reset in the middle of a grant.
    dma_req = 1'b1;
    wait_for("mid_gnt_high", 1, 1'b1, 100);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("mid_rst_gnt",   int'(dma_gnt), 0);
    check("mid_rst_busrq", int'(cpu_busrq_n), 1);
    check("mid_rst_count", int'(grant_count), 0);
    exp_cnt = 0;
    reset = 1'b0;
    dma_req = 1'b0;
    settle();
    repeat (5) begin
      tick();
      check("idle_gnt", int'(dma_gnt), 0);
    end
    run_burst(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
